// File: rtl/instruction_fetch_unit.sv
// Fetch stage of the 8-bit accumulator CPU: loadable program memory, PC and a
// valid/ready instruction handshake toward the decoder, with jump and HALT support.
module instruction_fetch_unit #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter logic [7:0]  HALT_INSTR = 8'hFF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [7:0]            load_data,
    input  logic                  start,
    input  logic                  jump_en,
    input  logic [ADDR_WIDTH-1:0] jump_target,
    input  logic                  instr_ready,
    output logic [7:0]            instr_out,
    output logic                  instr_valid,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic                  running,
    output logic                  halted
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_PRESENT = 2'd2,
        S_HALTED  = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [7:0]            instr_q, instr_d;
    logic                  valid_q, valid_d;
    logic                  running_q, running_d;
    logic                  halted_q, halted_d;
    logic [7:0]            mem_q [DEPTH];

    logic handshake_c;
    logic is_halt_c;
    logic load_ok_c;

    assign handshake_c = (state_q == S_PRESENT) && valid_q && instr_ready;
    assign is_halt_c   = (instr_q == HALT_INSTR);
    assign load_ok_c   = load_en && !rst && ((state_q == S_IDLE) || (state_q == S_HALTED));

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            instr_q   <= 8'h00;
            valid_q   <= 1'b0;
            running_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            running_q <= running_d;
            halted_q  <= halted_d;
        end
    end

    // Program memory survives reset; writes only while not executing
    always_ff @(posedge clk) begin
        if (load_ok_c) begin
            mem_q[load_addr] <= load_data;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start) state_d = S_FETCH;
            S_FETCH:   state_d = S_PRESENT;
            S_PRESENT: begin
                if (handshake_c) begin
                    state_d = is_halt_c ? S_HALTED : S_FETCH;
                end
            end
            S_HALTED:  if (start) state_d = S_FETCH;
            default:   state_d = S_IDLE;
        endcase
    end

    // Output/datapath next values; HALT keeps the PC, so no wrap on a HALT at the top address
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        case (state_q)
            S_IDLE, S_HALTED: begin
                valid_d = 1'b0;
                if (start) pc_d = '0;
            end
            S_FETCH: begin
                instr_d = mem_q[pc_q];
                valid_d = 1'b1;
            end
            S_PRESENT: begin
                if (handshake_c) begin
                    valid_d = 1'b0;
                    if (!is_halt_c) begin
                        pc_d = jump_en ? jump_target : pc_q + ADDR_WIDTH'(1);
                    end
                end
            end
            default: valid_d = 1'b0;
        endcase
        running_d = (state_d == S_FETCH) || (state_d == S_PRESENT);
        halted_d  = (state_d == S_HALTED);
    end

    assign instr_out   = instr_q;
    assign instr_valid = valid_q;
    assign pc_out      = pc_q;
    assign running     = running_q;
    assign halted      = halted_q;

endmodule
